// File: rtl/text_cursor_ctrl.sv
// Byte-stream cursor controller for an 80x25 text screen.
// Owns cursor x/y and drives single-cycle character RAM writes.
module text_cursor_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 25,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam logic [6:0]  X_MAX  = 7'(COLS - 1);
  localparam logic [4:0]  Y_MAX  = 5'(ROWS - 1);
  localparam logic [10:0] A_LAST = 11'(COLS * ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

  state_t      state;
  logic [10:0] clr_cnt;
  logic [10:0] cur_addr;
  logic        accept;

  logic is_print;
  logic is_cr;
  logic is_lf;
  logic is_bs;
  logic is_left;
  logic is_right;
  logic is_up;
  logic is_down;
  logic is_ff;

  assign accept = char_valid && char_ready;

  assign cur_addr = 11'(cur_y) * 11'(COLS)
                  + 11'(cur_x);

  always_comb begin
    is_print = (char_in >= 8'h20)
            && (char_in <= 8'h7E);
    is_cr    = (char_in == 8'h0D);
    is_lf    = (char_in == 8'h0A);
    is_bs    = (char_in == 8'h08);
    is_left  = (char_in == 8'h11);
    is_right = (char_in == 8'h12);
    is_up    = (char_in == 8'h13);
    is_down  = (char_in == 8'h14);
    is_ff    = (char_in == 8'h0C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_x      <= '0;
      cur_y      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      char_ready <= 1'b1;
      clr_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_print: begin
                wr_en      <= 1'b1;
                wr_addr    <= cur_addr;
                wr_data    <= char_in;
                char_ready <= 1'b0;
                state      <= WRITE;
                if (cur_x != X_MAX) begin
                  cur_x <= cur_x + 7'd1;
                end else begin
                  cur_x <= '0;
                  cur_y <= (cur_y == Y_MAX)
                         ? 5'd0 : cur_y + 5'd1;
                end
              end
              is_bs: begin
                if (cur_x != 7'd0) begin
                  cur_x      <= cur_x - 7'd1;
                  wr_en      <= 1'b1;
                  wr_addr    <= cur_addr - 11'd1;
                  wr_data    <= BLANK;
                  char_ready <= 1'b0;
                  state      <= WRITE;
                end
              end
              is_cr: cur_x <= '0;
              is_lf: begin
                cur_y <= (cur_y == Y_MAX)
                       ? 5'd0 : cur_y + 5'd1;
              end
              is_left: begin
                if (cur_x != 7'd0)
                  cur_x <= cur_x - 7'd1;
              end
              is_right: begin
                if (cur_x != X_MAX)
                  cur_x <= cur_x + 7'd1;
              end
              is_up: begin
                if (cur_y != 5'd0)
                  cur_y <= cur_y - 5'd1;
              end
              is_down: begin
                if (cur_y != Y_MAX)
                  cur_y <= cur_y + 5'd1;
              end
              // First blank goes out with the accept edge.
              is_ff: begin
                state      <= CLEAR;
                busy       <= 1'b1;
                char_ready <= 1'b0;
                clr_cnt    <= '0;
                wr_en      <= 1'b1;
                wr_addr    <= '0;
                wr_data    <= BLANK;
              end
              default: ;
            endcase
          end
        end
        WRITE: begin
          wr_en      <= 1'b0;
          char_ready <= 1'b1;
          state      <= IDLE;
        end
        CLEAR: begin
          if (clr_cnt == A_LAST) begin
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            char_ready <= 1'b1;
            cur_x      <= '0;
            cur_y      <= '0;
            state      <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 11'd1;
            wr_addr <= clr_cnt + 11'd1;
          end
        end
        default: begin
          state      <= IDLE;
          wr_en      <= 1'b0;
          busy       <= 1'b0;
          char_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl.
// Expected RAM writes are queued; a negedge monitor pops them.
module tb_text_cursor_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  typedef struct packed {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  vectors = 0;
  int  miscompares = 0;
  int  sweep_n;

  text_cursor_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b0 && wr_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%0d data=%h",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          miscompares++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   wr_addr, wr_data, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_cur(input int x, input int y);
    chk("cur_x", int'(cur_x), x);
    chk("cur_y", int'(cur_y), y);
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back({11'(a), 8'(d)});
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    char_in    = b;
    char_valid = 1'b1;
    while (char_ready !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout byte=%h got ready=%b want 1",
               b, char_ready);
    end
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic goto_xy(input int x, input int y);
    repeat (79) send(8'h11);
    repeat (24) send(8'h13);
    repeat (x) send(8'h12);
    repeat (y) send(8'h14);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cur_x"}, int'(cur_x), 0);
    chk({tag, "_cur_y"}, int'(cur_y), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(char_ready), 1);
  endtask

  initial begin
    reset      = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_vals("rst");

    // 'A' at origin
    push(0, 8'h41);
    send(8'h41);
    chk_cur(1, 0);
    chk("a_ready_low", int'(char_ready), 0);
    chk("a_wr_en", int'(wr_en), 1);
    @(posedge clk); #1;
    chk("a_ready_back", int'(char_ready), 1);
    chk("a_wr_en_low", int'(wr_en), 0);

    // wrap at last cell and at row end
    goto_xy(79, 24);
    push(1999, 8'h5A);
    send(8'h5A);
    chk_cur(0, 0);
    goto_xy(79, 3);
    push(319, 8'h5A);
    send(8'h5A);
    chk_cur(0, 4);

    // backspace
    goto_xy(5, 2);
    push(164, 8'h20);
    send(8'h08);
    chk_cur(4, 2);
    goto_xy(0, 2);
    send(8'h08);
    chk_cur(0, 2);
    chk("bs0_ready", int'(char_ready), 1);
    chk("bs0_wr_en", int'(wr_en), 0);

    // arrow clamps, LF wrap, CR
    goto_xy(0, 0);
    send(8'h11);
    send(8'h13);
    chk_cur(0, 0);
    goto_xy(79, 24);
    send(8'h12);
    send(8'h14);
    chk_cur(79, 24);
    goto_xy(10, 24);
    send(8'h0A);
    chk_cur(10, 0);
    send(8'h0D);
    chk_cur(0, 0);

    // ignored bytes
    goto_xy(3, 1);
    send(8'h09);
    send(8'h7F);
    send(8'hFF);
    send(8'h00);
    send(8'h1B);
    chk_cur(3, 1);
    chk("ign_ready", int'(char_ready), 1);
    chk("ign_busy", int'(busy), 0);

    // full clear with a byte held during the sweep
    goto_xy(30, 12);
    for (int i = 0; i < 2000; i++) push(i, 8'h20);
    push(0, 8'h43);
    send(8'h0C);
    chk("ff_busy", int'(busy), 1);
    chk("ff_ready", int'(char_ready), 0);
    chk_cur(30, 12);
    fork
      begin
        sweep_n = 0;
        while (busy === 1'b1 && sweep_n < 3000) begin
          sweep_n++;
          @(posedge clk); #1;
        end
      end
      send(8'h43);
    join
    chk("sweep_cycles", sweep_n, 2000);
    chk_cur(1, 0);
    @(posedge clk); #1;
    chk("sweep_drain", exp_q.size(), 0);

    // reset during sweep
    for (int i = 0; i < 2000; i++) push(i, 8'h20);
    send(8'h0C);
    repeat (500) @(posedge clk);
    #1;
    chk("abort_busy_pre", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    push(0, 8'h42);
    send(8'h42);
    chk_cur(1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
